// File: rtl/alu_stream_pkg.sv
// Shared definitions for the ALU stream pipeline: opcode encoding and
// command/result field positions as functions of the operand width.
package alu_stream_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_NOT = 3'b111
    } alu_op_e;

    localparam int OP_W = 3;

    // Command word is {op, a, b} with op in the MSBs.
    function automatic int cmd_w(input int dw);
        return OP_W + 2 * dw;
    endfunction

    function automatic int op_lsb(input int dw);
        return 2 * dw;
    endfunction

    function automatic int a_lsb(input int dw);
        return dw;
    endfunction

    function automatic int b_lsb(input int dw);
        return 0 * dw;
    endfunction

    // Result word is {carry, zero, result}.
    function automatic int res_w(input int dw);
        return dw + 2;
    endfunction

    function automatic int zero_bit(input int dw);
        return dw;
    endfunction

    function automatic int carry_bit(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/param_fifo.sv
// First-word-fall-through FIFO with occupancy output; the head word is
// presented directly from storage the cycle after it is written.
module param_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic             wready_s;
    logic             rvalid_s;
    logic             push_s;
    logic             pop_s;

    assign wready_s = (level_q != LVL_FULL);
    assign rvalid_s = (level_q != {LW{1'b0}});
    assign wready   = wready_s;
    assign rvalid   = rvalid_s;
    assign rdata    = mem_q[rd_ptr_q];
    assign level    = level_q;

    // Next-state for pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_comb begin
        push_s   = wvalid && wready_s;
        pop_s    = rready && rvalid_s;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array carries no reset; a write during reset is suppressed.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/alu_stream_pipe.sv
// Streaming ALU: input FIFO -> single registered ALU stage -> output FIFO,
// with valid/ready handshakes on both ends and a result counter.
module alu_stream_pipe
    import alu_stream_pkg::*;
#(
    parameter int DW    = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3+2*DW-1:0]       wdata,
    input  logic                    wvalid,
    output logic                    wready,
    output logic                    rvalid,
    output logic [DW+1:0]           rdata,
    input  logic                    rready,
    output logic [$clog2(DEPTH):0]  in_level,
    output logic [$clog2(DEPTH):0]  out_level,
    output logic [CNT_W-1:0]        op_count
);

    localparam int CMD_W = cmd_w(DW);
    localparam int RES_W = res_w(DW);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CMD_W-1:0] in_rdata_s;
    logic             in_rvalid_s;
    logic             out_wready_s;
    logic             stage_ready_s;
    logic             in_pop_s;
    logic             out_push_s;

    alu_op_e          op_s;
    logic [DW-1:0]    a_s;
    logic [DW-1:0]    b_s;
    logic [DW:0]      wide_s;
    logic [DW-1:0]    res_s;
    logic             carry_s;
    logic [RES_W-1:0] alu_word_s;

    logic             stage_valid_q;
    logic             stage_valid_d;
    logic [RES_W-1:0] stage_data_q;
    logic [RES_W-1:0] stage_data_d;
    logic [CNT_W-1:0] op_count_q;
    logic [CNT_W-1:0] op_count_d;

    param_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_in_fifo (
        .clk    (clk),
        .reset  (reset),
        .wdata  (wdata),
        .wvalid (wvalid),
        .wready (wready),
        .rdata  (in_rdata_s),
        .rvalid (in_rvalid_s),
        .rready (stage_ready_s),
        .level  (in_level)
    );

    param_fifo #(
        .WIDTH (RES_W),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk    (clk),
        .reset  (reset),
        .wdata  (stage_data_q),
        .wvalid (stage_valid_q),
        .wready (out_wready_s),
        .rdata  (rdata),
        .rvalid (rvalid),
        .rready (rready),
        .level  (out_level)
    );

    assign op_count = op_count_q;

    // Combinational ALU evaluated on the input FIFO head.
    always_comb begin
        op_s    = alu_op_e'(in_rdata_s[op_lsb(DW) +: OP_W]);
        a_s     = in_rdata_s[a_lsb(DW) +: DW];
        b_s     = in_rdata_s[b_lsb(DW) +: DW];
        wide_s  = {(DW+1){1'b0}};
        res_s   = {DW{1'b0}};
        carry_s = 1'b0;
        case (op_s)
            OP_ADD: begin
                wide_s  = {1'b0, a_s} + {1'b0, b_s};
                res_s   = wide_s[DW-1:0];
                carry_s = wide_s[DW];
            end
            OP_SUB: begin
                // The extra MSB of the widened difference is the borrow (a < b).
                wide_s  = {1'b0, a_s} - {1'b0, b_s};
                res_s   = wide_s[DW-1:0];
                carry_s = wide_s[DW];
            end
            OP_AND: res_s = a_s & b_s;
            OP_OR:  res_s = a_s | b_s;
            OP_XOR: res_s = a_s ^ b_s;
            OP_SHL: begin
                res_s   = {a_s[DW-2:0], 1'b0};
                carry_s = a_s[DW-1];
            end
            OP_SHR: begin
                res_s   = {1'b0, a_s[DW-1:1]};
                carry_s = a_s[0];
            end
            OP_NOT: res_s = ~a_s;
            default: begin
                res_s   = {DW{1'b0}};
                carry_s = 1'b0;
            end
        endcase
        alu_word_s                 = {RES_W{1'b0}};
        alu_word_s[DW-1:0]         = res_s;
        alu_word_s[zero_bit(DW)]   = (res_s == {DW{1'b0}});
        alu_word_s[carry_bit(DW)]  = carry_s;
    end

    // Stage handshake: it refills when empty or when its word drains this cycle.
    always_comb begin
        stage_ready_s = !stage_valid_q || out_wready_s;
        in_pop_s      = in_rvalid_s && stage_ready_s;
        out_push_s    = stage_valid_q && out_wready_s;
        stage_valid_d = stage_valid_q;
        stage_data_d  = stage_data_q;
        op_count_d    = op_count_q;
        if (in_pop_s) begin
            stage_valid_d = 1'b1;
            stage_data_d  = alu_word_s;
        end else if (out_push_s) begin
            stage_valid_d = 1'b0;
            stage_data_d  = stage_data_q;
        end else begin
            stage_valid_d = stage_valid_q;
            stage_data_d  = stage_data_q;
        end
        if (out_push_s) begin
            op_count_d = op_count_q + CNT_ONE;
        end else begin
            op_count_d = op_count_q;
        end
    end

    // Stage and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid_q <= 1'b0;
            stage_data_q  <= {RES_W{1'b0}};
            op_count_q    <= {CNT_W{1'b0}};
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            op_count_q    <= op_count_d;
        end
    end

endmodule

// File: tb/tb_alu_stream_pipe.sv
// Directed and randomized bench for alu_stream_pipe against an arithmetic
// reference model and an expected-result queue.
module tb_alu_stream_pipe;

    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic        clk;
    logic        reset;
    logic [10:0] wdata;
    logic        wvalid;
    logic        wready;
    logic        rvalid;
    logic [5:0]  rdata;
    logic        rready;
    logic [2:0]  in_level;
    logic [2:0]  out_level;
    logic [15:0] op_count;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         since_reset = 0;
    logic [5:0] exp_q[$];
    logic [5:0] got_q[$];

    alu_stream_pipe #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wdata     (wdata),
        .wvalid    (wvalid),
        .wready    (wready),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .rready    (rready),
        .in_level  (in_level),
        .out_level (out_level),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] ref_result(input int op, input int a, input int b);
        int   r;
        int   c;
        logic z;
        r = 0;
        c = 0;
        case (op)
            0: begin r = a + b; c = (r > 15) ? 1 : 0; r = r % 16; end
            1: begin c = (a < b) ? 1 : 0; r = (a - b + 16) % 16; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = (a * 2) % 16; c = (a >= 8) ? 1 : 0; end
            6: begin r = a / 2; c = a % 2; end
            default: r = 15 - a;
        endcase
        z = (r == 0);
        return {c[0], z, r[3:0]};
    endfunction

    function automatic logic [10:0] mk(input int op, input int a, input int b);
        return {op[2:0], a[3:0], b[3:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, book handshakes, advance to the next falling edge.
    task automatic cycle(input logic wv, input logic [10:0] wd, input logic rr);
        wvalid = wv;
        wdata  = wd;
        rready = rr;
        if (wv && wready) begin
            exp_q.push_back(ref_result(int'(wd[10:8]), int'(wd[7:4]), int'(wd[3:0])));
            since_reset++;
        end
        if (rr && rvalid) begin
            got_q.push_back(rdata);
            if (exp_q.size() == 0) begin
                check("result_expected", 32'(exp_q.size() > 0), 32'd1);
            end else begin
                check("data", 32'(rdata), 32'(exp_q.pop_front()));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && (exp_q.size() > 0 || rvalid); i++) begin
            cycle(1'b0, 11'd0, 1'b1);
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        check("drain_rvalid", 32'(rvalid), 32'd0);
    endtask

    // Reset with both handshakes asserted; nothing from that cycle may survive.
    task automatic do_reset();
        reset  = 1'b1;
        wvalid = 1'b1;
        wdata  = mk(0, 1, 1);
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        wvalid = 1'b0;
        rready = 1'b0;
        wdata  = 11'd0;
        exp_q.delete();
        got_q.delete();
        since_reset = 0;
    endtask

    initial begin
        int acc0;
        reset  = 1'b1;
        wvalid = 1'b0;
        rready = 1'b0;
        wdata  = 11'd0;
        @(negedge clk);
        do_reset();
        check("rst_wready", 32'(wready), 32'd1);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_in_level", 32'(in_level), 32'd0);
        check("rst_out_level", 32'(out_level), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);

        // ADD 9+8: accepted at edge 0, visible in cycle 3.
        cycle(1'b1, mk(0, 9, 8), 1'b1);
        check("lat_c1_rvalid", 32'(rvalid), 32'd0);
        cycle(1'b0, 11'd0, 1'b1);
        check("lat_c2_rvalid", 32'(rvalid), 32'd0);
        cycle(1'b0, 11'd0, 1'b1);
        check("lat_c3_rvalid", 32'(rvalid), 32'd1);
        check("lat_c3_rdata", 32'(rdata), 32'h21);
        check("lat_c3_op_count", 32'(op_count), 32'd1);
        drain();

        got_q.delete();
        cycle(1'b1, mk(1, 3, 5), 1'b1);
        cycle(1'b1, mk(1, 5, 5), 1'b1);
        drain();
        check("sub_count", 32'(got_q.size()), 32'd2);
        check("sub_borrow", 32'(got_q[0]), 32'h2e);
        check("sub_zero", 32'(got_q[1]), 32'h10);

        // Backpressure: 4 in output FIFO + 1 in stage + 4 in input FIFO.
        got_q.delete();
        acc0 = since_reset;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, mk($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15)), 1'b0);
        end
        check("bp_accepted", 32'(since_reset - acc0), 32'd9);
        check("bp_wready", 32'(wready), 32'd0);
        check("bp_in_level", 32'(in_level), 32'd4);
        check("bp_out_level", 32'(out_level), 32'd4);
        drain();
        check("bp_results", 32'(got_q.size()), 32'd9);
        check("bp_op_count", 32'(op_count), 32'(since_reset));

        got_q.delete();
        cycle(1'b1, mk(5, 8, 0), 1'b1);
        cycle(1'b1, mk(6, 1, 0), 1'b1);
        cycle(1'b1, mk(7, 15, 0), 1'b1);
        drain();
        check("shl", 32'(got_q[0]), 32'h30);
        check("shr", 32'(got_q[1]), 32'h30);
        check("not", 32'(got_q[2]), 32'h10);

        // Random valid/ready at 50%, exactly 1000 commands.
        do_reset();
        for (int cyc = 0; cyc < 20000 && since_reset < 1000; cyc++) begin
            cycle(((since_reset < 1000) && ($urandom_range(0, 1) == 1)),
                  mk($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15)),
                  ($urandom_range(0, 1) == 1));
        end
        check("rand_accepted", 32'(since_reset), 32'd1000);
        drain();
        check("rand_results", 32'(got_q.size()), 32'd1000);
        check("rand_op_count", 32'(op_count), 32'd1000);

        // Reset with the pipeline full.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, mk(0, i, 3), 1'b0);
        end
        check("full_out_level", 32'(out_level), 32'd4);
        do_reset();
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_wready", 32'(wready), 32'd1);
        check("mid_rst_in_level", 32'(in_level), 32'd0);
        check("mid_rst_out_level", 32'(out_level), 32'd0);
        check("mid_rst_op_count", 32'(op_count), 32'd0);
        cycle(1'b1, mk(4, 12, 10), 1'b1);
        drain();
        check("post_rst_count", 32'(got_q.size()), 32'd1);
        check("post_rst_xor", 32'(got_q[0]), 32'h06);
        check("post_rst_op_count", 32'(op_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
